// File: rtl/rvfpm_result_sched.sv
// rvfpm_result_sched
// Result-channel scheduler for the rvfpm coprocessor. Round-robin arbitrates
// completed results from NUM_SRC producers into a 2-entry FIFO. The FIFO head
// drives the single CORE-V-XIF result interface.
//
// Parameters:
//   NUM_SRC      number of result producers (2..4)
//   X_ID_WIDTH   instruction id width
//   X_RFW_WIDTH  result data width
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   src_valid         per-producer result valid
//   src_ready         per-producer accept, one-hot or zero
//   src_id/data/rd    per-producer result fields, held until accepted
//   result_valid      head-of-FIFO valid (FIFO not empty)
//   result_ready      core accepts the head entry
//   result_id/data/rd head-of-FIFO result fields
//   result_stall_cnt  saturating count of cycles with result_valid && !result_ready
//                     (only present when RVFPM_RESULT_STATS_EN is defined)
//
// Optional feature macro: RVFPM_RESULT_STATS_EN
module rvfpm_result_sched #(
    parameter int NUM_SRC     = 2,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_SRC-1:0]                      src_valid,
    output logic [NUM_SRC-1:0]                      src_ready,
    input  logic [NUM_SRC-1:0][X_ID_WIDTH-1:0]      src_id,
    input  logic [NUM_SRC-1:0][X_RFW_WIDTH-1:0]     src_data,
    input  logic [NUM_SRC-1:0][4:0]                 src_rd,
    output logic                                    result_valid,
    input  logic                                    result_ready,
    output logic [X_ID_WIDTH-1:0]                   result_id,
    output logic [X_RFW_WIDTH-1:0]                  result_data,
    output logic [4:0]                              result_rd
`ifdef RVFPM_RESULT_STATS_EN
    ,
    output logic [15:0]                             result_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_SRC);

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
    } entry_t;

    entry_t             mem_r [2];
    logic               wr_ptr_r;
    logic               rd_ptr_r;
    logic [1:0]         count_r;
    logic [PTR_W-1:0]   rr_ptr_r;

    logic [PTR_W-1:0]   cand_idx_s [NUM_SRC];
    logic [NUM_SRC-1:0] grant_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic               found_s;
    logic               space_s;
    logic               push_s;
    logic               pop_s;
    entry_t             push_entry_s;
    entry_t             head_s;

    // Source indices in priority order, starting at the round-robin pointer and wrapping.
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            cand_idx_s[k] = PTR_W'((int'(rr_ptr_r) + k) % NUM_SRC);
        end
    end

    // Round-robin arbiter: first requesting source at or after rr_ptr wins.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        found_s     = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found_s && src_valid[cand_idx_s[k]]) begin
                grant_s[cand_idx_s[k]] = 1'b1;
                grant_idx_s            = cand_idx_s[k];
                found_s                = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Handshake decode; space depends only on the registered count so the
    // producer side never waits combinationally on result_ready.
    always_comb begin
        space_s           = (count_r != 2'd2);
        src_ready         = grant_s & {NUM_SRC{space_s && rst_n}};
        push_s            = |(src_valid & src_ready);
        pop_s             = (count_r != 2'd0) && result_ready;
        push_entry_s.id   = src_id[grant_idx_s];
        push_entry_s.data = src_data[grant_idx_s];
        push_entry_s.rd   = src_rd[grant_idx_s];
        head_s            = mem_r[rd_ptr_r];
        result_valid      = (count_r != 2'd0);
        result_id         = head_s.id;
        result_data       = head_s.data;
        result_rd         = head_s.rd;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // FIFO storage; reset clears it so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= push_entry_s;
        end
    end

    // Round-robin pointer advances past the winner only on an actual transfer,
    // so a grant blocked by a full FIFO keeps its turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (push_s) begin
            rr_ptr_r <= PTR_W'((int'(grant_idx_s) + 1) % NUM_SRC);
        end
    end

`ifdef RVFPM_RESULT_STATS_EN
    logic [15:0] stall_cnt_r;

    // Saturating stall counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'd0;
        end else if (result_valid && !result_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign result_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_rvfpm_result_sched.sv
// Testbench for rvfpm_result_sched: a directed vector table, hand-written
// sequences for reset and backpressure, and a randomized phase checked against
// a queue-based reference model.
module tb_rvfpm_result_sched;

    localparam int N  = 2;
    localparam int IW = 4;
    localparam int DW = 32;

    logic                   clk;
    logic                   rst_n;
    logic [N-1:0]           src_valid;
    logic [N-1:0]           src_ready;
    logic [N-1:0][IW-1:0]   src_id;
    logic [N-1:0][DW-1:0]   src_data;
    logic [N-1:0][4:0]      src_rd;
    logic                   result_valid;
    logic                   result_ready;
    logic [IW-1:0]          result_id;
    logic [DW-1:0]          result_data;
    logic [4:0]             result_rd;
`ifdef RVFPM_RESULT_STATS_EN
    logic [15:0]            result_stall_cnt;
`endif

    rvfpm_result_sched #(
        .NUM_SRC    (N),
        .X_ID_WIDTH (IW),
        .X_RFW_WIDTH(DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_id      (src_id),
        .src_data    (src_data),
        .src_rd      (src_rd),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_id   (result_id),
        .result_data (result_data),
        .result_rd   (result_rd)
`ifdef RVFPM_RESULT_STATS_EN
        ,
        .result_stall_cnt(result_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [4:0]    rd;
    } res_t;

    // Reference model: an ordered queue of buffered results and a turn index.
    res_t model_q[$];
    int   model_rr;
    int   last_grant;

    typedef struct {
        logic [N-1:0] valid;
        logic         rready;
        logic [N-1:0] exp_ready;
        logic         exp_rvalid;
        int           exp_src;
    } vec_t;

    vec_t          vecs [12];
    logic [IW-1:0] tab_id   [N];
    logic [DW-1:0] tab_data [N];
    logic [4:0]    tab_rd   [N];
    logic [N-1:0]  pend;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Grant the model predicts: none when two results are buffered, else the
    // first valid source at or after the turn index, wrapping around.
    function automatic int model_grant(input logic [N-1:0] v);
        if (model_q.size() >= 2) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(model_rr + k) % N]) return (model_rr + k) % N;
        end
        return -1;
    endfunction

    // Compare one cycle against the model (inputs already driven after a negedge),
    // then advance the model across the following rising edge.
    task automatic model_cycle();
        int g;
        logic [N-1:0] er;
        #1;
        g  = model_grant(src_valid);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("src_ready", 64'(src_ready), 64'(er));
        check("result_valid", 64'(result_valid), 64'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            check("result_id", 64'(result_id), 64'(model_q[0].id));
            check("result_data", 64'(result_data), 64'(model_q[0].data));
            check("result_rd", 64'(result_rd), 64'(model_q[0].rd));
        end
        @(posedge clk);
        if (model_q.size() != 0 && result_ready) void'(model_q.pop_front());
        if (g >= 0) begin
            model_q.push_back('{id: src_id[g], data: src_data[g], rd: src_rd[g]});
            model_rr = (g + 1) % N;
        end
        last_grant = g;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        src_valid    = '0;
        result_ready = 1'b0;
        src_id       = '0;
        src_data     = '0;
        src_rd       = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        model_rr = 0;
    endtask

    initial begin
        // A = src0, B = src1; every row is one cycle starting from reset.
        vecs[0]  = '{2'b11, 1'b1, 2'b01, 1'b0, -1};
        vecs[1]  = '{2'b11, 1'b1, 2'b10, 1'b1,  0};
        vecs[2]  = '{2'b11, 1'b0, 2'b01, 1'b1,  1};
        vecs[3]  = '{2'b11, 1'b0, 2'b00, 1'b1,  1};
        vecs[4]  = '{2'b11, 1'b1, 2'b00, 1'b1,  1};
        vecs[5]  = '{2'b11, 1'b1, 2'b10, 1'b1,  0};
        vecs[6]  = '{2'b00, 1'b1, 2'b00, 1'b1,  1};
        vecs[7]  = '{2'b00, 1'b1, 2'b00, 1'b0, -1};
        vecs[8]  = '{2'b10, 1'b0, 2'b10, 1'b0, -1};
        vecs[9]  = '{2'b00, 1'b0, 2'b00, 1'b1,  1};
        vecs[10] = '{2'b00, 1'b1, 2'b00, 1'b1,  1};
        vecs[11] = '{2'b00, 1'b1, 2'b00, 1'b0, -1};
        tab_id[0] = 4'hA; tab_data[0] = 32'h3F80_0000; tab_rd[0] = 5'd5;
        tab_id[1] = 4'hB; tab_data[1] = 32'h4000_0000; tab_rd[1] = 5'd7;

        // Reset state, including src_ready held low while in reset.
        rst_n        = 1'b0;
        src_valid    = 2'b11;
        result_ready = 1'b1;
        src_id       = '0;
        src_data     = '0;
        src_rd       = '0;
        #2;
        check("rst_src_ready", 64'(src_ready), 64'd0);
        check("rst_result_valid", 64'(result_valid), 64'd0);
        check("rst_result_id", 64'(result_id), 64'd0);
        check("rst_result_data", 64'(result_data), 64'd0);
        check("rst_result_rd", 64'(result_rd), 64'd0);
        do_reset();

        // Single-source transfer and one-cycle latency.
        src_valid[0] = 1'b1; src_id[0] = 4'd3; src_data[0] = 32'h3F80_0000; src_rd[0] = 5'd5;
        result_ready = 1'b1;
        #1;
        check("single_ready", 64'(src_ready), 64'b01);
        check("single_empty", 64'(result_valid), 64'd0);
        @(negedge clk);
        src_valid = '0;
        #1;
        check("single_valid", 64'(result_valid), 64'd1);
        check("single_id", 64'(result_id), 64'd3);
        check("single_data", 64'(result_data), 64'h3F80_0000);
        check("single_rd", 64'(result_rd), 64'd5);
        @(negedge clk);
        #1;
        check("single_drained", 64'(result_valid), 64'd0);

        // Directed vector table: round-robin, backpressure and grant hold.
        do_reset();
        for (int i = 0; i < N; i++) begin
            src_id[i] = tab_id[i]; src_data[i] = tab_data[i]; src_rd[i] = tab_rd[i];
        end
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            src_valid    = vecs[r].valid;
            result_ready = vecs[r].rready;
            #1;
            check($sformatf("vec%0d_ready", r), 64'(src_ready), 64'(vecs[r].exp_ready));
            check($sformatf("vec%0d_rvalid", r), 64'(result_valid), 64'(vecs[r].exp_rvalid));
            if (vecs[r].exp_src >= 0) begin
                check($sformatf("vec%0d_id", r), 64'(result_id), 64'(tab_id[vecs[r].exp_src]));
                check($sformatf("vec%0d_data", r), 64'(result_data), 64'(tab_data[vecs[r].exp_src]));
                check($sformatf("vec%0d_rd", r), 64'(result_rd), 64'(tab_rd[vecs[r].exp_src]));
            end
        end

        // Reset mid-operation with a full FIFO.
        do_reset();
        src_valid = 2'b01; src_id[0] = 4'd1;
        @(negedge clk);
        src_id[0] = 4'd2;
        @(negedge clk);
        #1;
        check("full_ready", 64'(src_ready), 64'd0);
        check("full_head", 64'(result_id), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(result_valid), 64'd0);
        check("async_rst_ready", 64'(src_ready), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        src_valid = 2'b11;
        #1;
        check("post_rst_valid", 64'(result_valid), 64'd0);
        check("post_rst_rr", 64'(src_ready), 64'b01);

        // Randomized traffic against the reference model.
        do_reset();
        pend = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
                    pend[i]     = 1'b1;
                    src_id[i]   = IW'($urandom);
                    src_data[i] = $urandom;
                    src_rd[i]   = 5'($urandom);
                end
            end
            src_valid    = pend;
            result_ready = (cyc >= 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (cyc >= 300) src_valid = '1;
            model_cycle();
            if (last_grant >= 0) pend[last_grant] = 1'b0;
        end

`ifdef RVFPM_RESULT_STATS_EN
        do_reset();
        src_valid = 2'b01;
        @(negedge clk);
        src_valid = '0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_cnt_10", 64'(result_stall_cnt), 64'd10);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        check("stall_cnt_sat", 64'(result_stall_cnt), 64'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rvfpm_result_sched.md
# rvfpm_result_sched

Result-channel scheduler for the rvfpm coprocessor. Arbitrates completed results from NUM_SRC producers (FP execution pipeline, load unit, CSR/move path) onto the single CORE-V-XIF result interface (x_result_t fields id/data/rd) using round-robin grants. Results are buffered in a 2-entry output FIFO, so producer handshakes have no combinational dependency on core `result_ready`.

## Interface
- NUM_SRC, 2, number of result producers (2..4)
- X_ID_WIDTH, 4, instruction id width (matches pa_rvfpm)
- X_RFW_WIDTH, 32, result data width (matches pa_rvfpm)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- src_valid  in  NUM_SRC  per-producer result valid
- src_ready  out  NUM_SRC  per-producer accept, one-hot or zero
- src_id  in  NUM_SRC×X_ID_WIDTH  per-producer instruction id
- src_data  in  NUM_SRC×X_RFW_WIDTH  per-producer writeback data
- src_rd  in  NUM_SRC×5  per-producer destination register
- result_valid  out  1  XIF result valid
- result_ready  in  1  XIF result accept from core
- result_id / result_data / result_rd  out  X_ID_WIDTH / X_RFW_WIDTH / 5  head-of-FIFO result fields
- result_stall_cnt  out  16  present only with RVFPM_RESULT_STATS_EN

## Operation
- FIFO: 2 entries, write pointer, read pointer (1 bit each), occupancy count 0..2.
- Pop: result_valid && result_ready; head entry is removed at the clock edge.
- Push allowed when count < 2, based on registered count only (no result_ready path).
- Arbiter: round-robin pointer rr_ptr (clog2(NUM_SRC) bits). Grant goes to the first requesting source at or after rr_ptr, in index order with wrap-around.
- src_ready[i] = grant[i] && (count < 2). All src_ready are 0 when the FIFO is full or nothing is requested.
- Transfer from source i occurs when src_valid[i] && src_ready[i]. The entry {id, data, rd} is written at wr_ptr.
- rr_ptr moves to (i+1) mod NUM_SRC only on a transfer. It holds when no transfer occurs, so a blocked grant does not lose its turn.
- Simultaneous push and pop: allowed at count 1 and count 2→ no. At count 2 push is blocked (ready low), and a pop reduces count to 1. At count 1 push and pop together leave count at 1. At count 0 a push takes count to 1.
- Producers hold valid and fields stable until accepted. The block does not check this.
- Reset mid-operation: all buffered results are discarded. Producers must re-drive after reset.

## Timing
- Latency: a result accepted at edge N is visible on result_* with result_valid=1 after edge N (registered output, 1 cycle). Back-to-back throughput is 1 result/cycle while result_ready=1.
- result_valid = (count != 0). result_* are driven from the FIFO head register array, not muxed from the sources.
- Reset values: result_valid 0, result_id/data/rd 0, count 0, wr_ptr/rd_ptr 0, rr_ptr 0, FIFO storage 0, result_stall_cnt 0. src_ready is combinational and is 0 while in reset.
- result_* stay stable while result_valid && !result_ready (XIF rule).
- Fairness bound: with all sources continuously valid and result_ready=1, each source is granted once every NUM_SRC transfers.

## Configuration
- RVFPM_RESULT_STATS_EN defined:
  - result_stall_cnt port and a 16-bit counter are present.
  - The counter increments each cycle that result_valid && !result_ready, saturates at 16'hFFFF, and is cleared only by rst_n.
- Not defined: no port and no counter logic. Behaviour is otherwise identical.

## Test plan
- Single source: src_valid[0]=1 with id=3, data=32'h3F80_0000, rd=5, result_ready=1 → src_ready[0]=1 in that cycle; next cycle result_valid=1, id=3, data=3F80_0000, rd=5; FIFO is empty the cycle after.
- Round-robin: both sources valid continuously, result_ready=1, rr_ptr=0 → accept order is src0, src1, src0, src1, with one result/cycle.
- Backpressure: result_ready=0, src0 pushes ids 1 then 2 → third cycle src_ready=0 for all; result_* hold id=1. Raise result_ready → id=1 pops, then id=2; src_ready reasserts the cycle after the first pop.
- Grant hold: rr_ptr at src1, FIFO full, src1 valid → src1 is served first once space frees, even though src0 is also valid.
- Reset mid-operation: FIFO holds 2 entries, assert rst_n=0 for one cycle → result_valid=0 immediately (asynchronous); after release count=0 and rr_ptr=0.
- Stats (RVFPM_RESULT_STATS_EN): hold result_valid=1, result_ready=0 for 10 cycles → result_stall_cnt=10. Force 70000 stall cycles → counter reads 16'hFFFF.
